// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the APB real-time counter.
//  - Register byte offsets, CTRL bit indices, ALARM window base.
//  - reg_sel_e names the register selected by an APB address.
//  - reg_decode() maps a word-aligned byte address to reg_sel_e.
package rtc_pkg;

   localparam int unsigned TIME_OFFS   = 'h00;
   localparam int unsigned CTRL_OFFS   = 'h04;
   localparam int unsigned ADJ_OFFS    = 'h08;
   localparam int unsigned STATUS_OFFS = 'h0C;
   localparam int unsigned IRQ_EN_OFFS = 'h10;
   localparam int unsigned ALARM_BASE  = 'h20;

   localparam int unsigned CTRL_EN_BIT      = 0;
   localparam int unsigned CTRL_CLR_PRE_BIT = 1;

   typedef enum logic [2:0] {
      RegTime,
      RegCtrl,
      RegAdj,
      RegStatus,
      RegIrqEn,
      RegAlarm,
      RegNone
   } reg_sel_e;

   // byte_addr must already have bits [1:0] cleared.
   function automatic reg_sel_e reg_decode(input int unsigned byte_addr,
                                           input int unsigned n_alarm);
      if (byte_addr == TIME_OFFS)        return RegTime;
      else if (byte_addr == CTRL_OFFS)   return RegCtrl;
      else if (byte_addr == ADJ_OFFS)    return RegAdj;
      else if (byte_addr == STATUS_OFFS) return RegStatus;
      else if (byte_addr == IRQ_EN_OFFS) return RegIrqEn;
      else if (byte_addr >= ALARM_BASE && byte_addr < ALARM_BASE + 4 * n_alarm) return RegAlarm;
      return RegNone;
   endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides pclk into a one-cycle tick enable every PRESCALE cycles.
// Ports:
//  pclk   in   bus clock
//  preset in   asynchronous active-high reset
//  en     in   count enable; when low the count holds and no tick is produced
//  clr    in   clear the count to 0 (wins over counting, suppresses the tick)
//  tick   out  high for the cycle in which the count wraps PRESCALE-1 -> 0
module rtc_prescaler #(
   parameter int unsigned PRESCALE = 10
) (
   input  logic pclk,
   input  logic preset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned PRE_W = $clog2(PRESCALE);
   localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] cnt_q, cnt_d;

   assign tick = en & ~clr & (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PRE_W'(1);
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/apb_rtc_multi_alarm.sv
// apb_rtc_multi_alarm: APB3 zero-wait real-time counter with N_ALARM compare channels.
// Ports:
//  pclk, preset            clock, asynchronous active-high reset
//  psel, penable, pwrite   APB control
//  paddr                   byte address ([1:0] ignored)
//  pwdata / prdata         write / read data (prdata is 0 outside a read access)
//  pready                  psel & penable, combinational
//  pslverr                 access to an unmapped address
//  irq                     registered OR of STATUS & IRQ_EN
module apb_rtc_multi_alarm
   import rtc_pkg::*;
#(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned PRESCALE = 10,
   parameter int unsigned N_ALARM  = 4,
   parameter int unsigned ADDR_W   = 8
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              irq
);

   localparam int unsigned AIDX_W = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

   logic               access, we, tick, clr_pre;
   int unsigned        byte_addr;
   reg_sel_e           sel;
   logic [AIDX_W-1:0]  aidx;
   logic [31:0]        rdata;
   logic               unused_addr;

   logic [CNT_W-1:0]   time_q, time_d;
   logic               ctrl_en_q;
   logic [N_ALARM-1:0] status_q, status_d, irq_en_q, hit;
   logic [CNT_W-1:0]   alarm_q [N_ALARM];
   logic               irq_q;

   // Outputs are forced to their reset values while preset is held.
   assign access      = psel & penable & ~preset;
   assign we          = access & pwrite;
   assign byte_addr   = 32'({paddr[ADDR_W-1:2], 2'b00});
   assign aidx        = paddr[AIDX_W+1:2];
   assign unused_addr = ^paddr[1:0];

   always_comb begin
      sel = reg_decode(byte_addr, N_ALARM);
   end

   assign clr_pre = we & (sel == RegCtrl) & pwdata[CTRL_CLR_PRE_BIT];

   rtc_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .pclk   (pclk),
      .preset (preset),
      .en     (ctrl_en_q),
      .clr    (clr_pre),
      .tick   (tick)
   );

   // TIME write beats ADJ beats tick; a TIME write discards a coincident tick.
   always_comb begin
      time_d = time_q + CNT_W'(tick);
      if (we && sel == RegTime) begin
         time_d = pwdata[CNT_W-1:0];
      end else if (we && sel == RegAdj) begin
         time_d = time_q + pwdata[CNT_W-1:0] + CNT_W'(tick);
      end
   end

   // A flag sets only when TIME moves onto the alarm value, not while it sits there.
   for (genvar i = 0; i < N_ALARM; i++) begin : g_alarm
      assign hit[i] = (time_d != time_q) && (time_d == alarm_q[i]);

      always_ff @(posedge pclk or posedge preset) begin
         if (preset) begin
            alarm_q[i] <= '1;
         end else if (we && sel == RegAlarm && aidx == AIDX_W'(i)) begin
            alarm_q[i] <= pwdata[CNT_W-1:0];
         end
      end
   end

   // Set wins over a coincident W1C.
   always_comb begin
      status_d = status_q;
      if (we && sel == RegStatus) status_d = status_d & ~pwdata[N_ALARM-1:0];
      status_d = status_d | hit;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         time_q    <= '0;
         ctrl_en_q <= 1'b0;
         status_q  <= '0;
         irq_en_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         time_q   <= time_d;
         status_q <= status_d;
         irq_q    <= |(status_q & irq_en_q);
         if (we && sel == RegCtrl)  ctrl_en_q <= pwdata[CTRL_EN_BIT];
         if (we && sel == RegIrqEn) irq_en_q  <= pwdata[N_ALARM-1:0];
      end
   end

   always_comb begin
      rdata = '0;
      unique case (sel)
         RegTime:   rdata = 32'(time_q);
         RegCtrl:   rdata[CTRL_EN_BIT] = ctrl_en_q;
         RegStatus: rdata[N_ALARM-1:0] = status_q;
         RegIrqEn:  rdata[N_ALARM-1:0] = irq_en_q;
         RegAlarm:  rdata = 32'(alarm_q[aidx]);
         default:   rdata = '0;
      endcase
   end

   assign pready  = access;
   assign pslverr = access & (sel == RegNone);
   assign prdata  = (access & ~pwrite) ? rdata : '0;
   assign irq     = irq_q;

endmodule

// File: tb/tb_apb_rtc_multi_alarm.sv
module tb_apb_rtc_multi_alarm;

   localparam int unsigned PRESCALE = 10;

   logic        pclk = 1'b0;
   logic        preset, psel, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr, irq;

   always #5 pclk = ~pclk;

   apb_rtc_multi_alarm #(
      .CNT_W    (32),
      .PRESCALE (PRESCALE),
      .N_ALARM  (4),
      .ADDR_W   (8)
   ) dut (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr),
      .irq     (irq)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int cyc0;
   logic [31:0] last_rdata;
   logic        last_err;
   logic [31:0] rd;

   // Reference model: plain register values, updated once per clock edge.
   logic [31:0] m_time;
   int          m_pre;
   bit          m_en;
   logic [3:0]  m_status, m_irq_en;
   logic [31:0] m_alarm [4];
   bit          m_irq;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_time = 0; m_pre = 0; m_en = 0; m_status = 0; m_irq_en = 0; m_irq = 0;
      for (int i = 0; i < 4; i++) m_alarm[i] = 32'hFFFF_FFFF;
   endtask

   function automatic bit mapped(input logic [7:0] a);
      logic [7:0] w;
      w = a & 8'hFC;
      return (w == 8'h00 || w == 8'h04 || w == 8'h08 || w == 8'h0C || w == 8'h10 ||
              (w >= 8'h20 && w < 8'h30));
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      logic [7:0] w;
      w = a & 8'hFC;
      case (w)
         8'h00:                      return m_time;
         8'h04:                      return {31'b0, m_en};
         8'h0C:                      return {28'b0, m_status};
         8'h10:                      return {28'b0, m_irq_en};
         8'h20, 8'h24, 8'h28, 8'h2C: return m_alarm[w[3:2]];
         default:                    return 32'h0;
      endcase
   endfunction

   // One clock cycle: drive, check outputs mid-cycle against the model, advance model at the edge.
   task automatic step(input bit s, input bit e, input bit wr, input logic [7:0] a,
                       input logic [31:0] d);
      bit          acc, do_w, clr, tick, nirq;
      logic [7:0]  w;
      logic [31:0] nt;
      logic [3:0]  set, nstat;
      @(negedge pclk);
      psel = s; penable = e; pwrite = wr; paddr = a; pwdata = d;
      #1;
      acc = s && e;
      w = a & 8'hFC;
      last_rdata = prdata;
      last_err = pslverr;
      check("pready", {31'b0, pready}, {31'b0, acc});
      check("pslverr", {31'b0, pslverr}, {31'b0, acc && !mapped(a)});
      check("prdata", prdata, (acc && !wr) ? model_read(a) : 32'h0);
      check("irq", {31'b0, irq}, {31'b0, m_irq});

      do_w = acc && wr && mapped(a);
      clr  = do_w && w == 8'h04 && d[1];
      tick = m_en && !clr && m_pre == PRESCALE - 1;
      if (do_w && w == 8'h00)      nt = d;
      else if (do_w && w == 8'h08) nt = m_time + d + 32'(tick);
      else                         nt = m_time + 32'(tick);
      for (int i = 0; i < 4; i++) set[i] = (nt != m_time) && (nt == m_alarm[i]);
      nstat = m_status;
      if (do_w && w == 8'h0C) nstat = nstat & ~d[3:0];
      nstat = nstat | set;
      nirq = |(m_status & m_irq_en);

      @(posedge pclk);
      cyc++;
      if (clr)       m_pre = 0;
      else if (m_en) m_pre = (m_pre == PRESCALE - 1) ? 0 : m_pre + 1;
      m_time = nt;
      m_status = nstat;
      m_irq = nirq;
      if (do_w && w == 8'h04) m_en = d[0];
      if (do_w && w == 8'h10) m_irq_en = d[3:0];
      if (do_w && w >= 8'h20 && w < 8'h30) m_alarm[w[3:2]] = d;
   endtask

   task automatic idle();
      step(0, 0, 0, 8'h00, 32'h0);
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      step(1, 0, 1, a, d);
      step(1, 1, 1, a, d);
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
      step(1, 0, 0, a, 32'h0);
      step(1, 1, 0, a, 32'h0);
      d = last_rdata;
   endtask

   // Read whose access phase sees exactly k edges after cyc0.
   task automatic read_at(input int k, input logic [7:0] a, output logic [31:0] d);
      while (cyc - cyc0 < k - 1) idle();
      apb_read(a, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  addrs [14];
      logic [7:0]  a;
      logic [31:0] d;
      addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24, 8'h28, 8'h2C,
                8'h14, 8'h18, 8'h30, 8'h40, 8'hFC};

      preset = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
      model_reset();
      #1;
      check("rst_prdata", prdata, 32'h0);
      check("rst_pready", {31'b0, pready}, 32'h0);
      check("rst_pslverr", {31'b0, pslverr}, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      @(negedge pclk); @(negedge pclk);
      preset = 1'b0;

      apb_read(8'h00, rd); check("rst_time", rd, 32'h0);
      apb_read(8'h0C, rd); check("rst_status", rd, 32'h0);
      apb_read(8'h20, rd); check("rst_alarm0", rd, 32'hFFFF_FFFF);

      // 1: tick cadence
      apb_write(8'h04, 32'h1);
      cyc0 = cyc;
      read_at(9, 8'h00, rd);  check("t1_time_c9", rd, 32'd0);
      read_at(11, 8'h00, rd); check("t1_time_c11", rd, 32'd1);
      read_at(50, 8'h00, rd); check("t1_time_c50", rd, 32'd5);

      // 2: wrap to 0 hits ALARM[0]=0
      apb_write(8'h0C, 32'hF);
      apb_write(8'h20, 32'h0);
      apb_write(8'h10, 32'h1);
      apb_write(8'h04, 32'h3);
      cyc0 = cyc;
      apb_write(8'h00, 32'hFFFF_FFFF);
      apb_write(8'h0C, 32'hF);
      read_at(12, 8'h00, rd); check("t2_time_wrap", rd, 32'h0);
      apb_read(8'h0C, rd);    check("t2_status", rd, 32'h1);
      @(negedge pclk);        check("t2_irq", {31'b0, irq}, 32'h1);
      apb_write(8'h04, 32'h0);

      // 3: signed adjust, without and with a coincident tick
      apb_write(8'h00, 32'd100);
      apb_write(8'h08, 32'hFFFF_FFF6);
      apb_read(8'h00, rd); check("t3_adj", rd, 32'd90);
      apb_write(8'h04, 32'h3);
      cyc0 = cyc;
      while (cyc - cyc0 < 8) idle();
      apb_write(8'h08, 32'hFFFF_FFF6);
      apb_write(8'h04, 32'h0);
      apb_read(8'h00, rd); check("t3_adj_tick", rd, 32'd81);

      // 4: alarm 2, irq and W1C
      apb_write(8'h0C, 32'hF);
      apb_write(8'h28, 32'd5);
      apb_write(8'h10, 32'h4);
      apb_write(8'h00, 32'd4);
      apb_write(8'h00, 32'd5);
      idle(); idle();
      @(negedge pclk); check("t4_irq_set", {31'b0, irq}, 32'h1);
      apb_write(8'h0C, 32'h4);
      idle();
      @(negedge pclk); check("t4_irq_clr", {31'b0, irq}, 32'h0);
      apb_read(8'h0C, rd); check("t4_status_clr", rd, 32'h0);
      apb_write(8'h00, 32'd4);
      apb_write(8'h04, 32'h3);
      cyc0 = cyc;
      while (cyc - cyc0 < 8) idle();
      apb_write(8'h0C, 32'h4);
      apb_write(8'h04, 32'h0);
      apb_read(8'h0C, rd); check("t4_set_wins", rd, 32'h4);

      // 5: unmapped accesses
      apb_read(8'h14, rd);
      check("t5_rd_err", {31'b0, last_err}, 32'h1);
      check("t5_rd_data", rd, 32'h0);
      apb_write(8'h40, 32'hDEAD_BEEF);
      check("t5_wr_err", {31'b0, last_err}, 32'h1);
      apb_read(8'h00, rd); check("t5_time_kept", rd, 32'd5);

      // Randomized traffic, checked every cycle against the model.
      apb_write(8'h04, 32'h1);
      for (int n = 0; n < 400; n++) begin
         a = addrs[$urandom_range(0, 13)];
         case (a)
            8'h00:   d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 12));
            8'h08:   d = 32'($urandom_range(0, 6)) - 32'd3;
            8'h04:   d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h1;
            8'h20, 8'h24, 8'h28, 8'h2C: d = 32'($urandom_range(0, 12));
            default: d = $urandom;
         endcase
         a = a | 8'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) idle();
         if ($urandom_range(0, 1) == 1) apb_write(a, d);
         else                           apb_read(a, rd);
      end

      // 6: reset in the middle of a write
      apb_write(8'h04, 32'h0);
      apb_write(8'h20, 32'd6);
      apb_write(8'h24, 32'd7);
      apb_write(8'h28, 32'h1000);
      apb_write(8'h2C, 32'h1000);
      apb_write(8'h00, 32'd5);
      apb_write(8'h0C, 32'hF);
      apb_write(8'h10, 32'h3);
      apb_write(8'h00, 32'd6);
      apb_write(8'h00, 32'd7);
      apb_write(8'h04, 32'h1);
      apb_read(8'h0C, rd); check("t6_status_pre", rd, 32'h3);
      @(negedge pclk); check("t6_irq_pre", {31'b0, irq}, 32'h1);
      step(1, 0, 1, 8'h00, 32'h55);
      @(negedge pclk);
      psel = 1; penable = 1; pwrite = 1; paddr = 8'h00; pwdata = 32'h55;
      #2 preset = 1'b1;
      #1;
      check("t6_irq_async", {31'b0, irq}, 32'h0);
      check("t6_pready", {31'b0, pready}, 32'h0);
      check("t6_pslverr", {31'b0, pslverr}, 32'h0);
      model_reset();
      @(posedge pclk); @(negedge pclk);
      psel = 0; penable = 0; pwrite = 0;
      preset = 1'b0;
      apb_read(8'h00, rd); check("t6_time", rd, 32'h0);
      apb_read(8'h04, rd); check("t6_ctrl", rd, 32'h0);
      apb_read(8'h0C, rd); check("t6_status", rd, 32'h0);
      apb_read(8'h10, rd); check("t6_irq_en", rd, 32'h0);
      apb_read(8'h24, rd); check("t6_alarm1", rd, 32'hFFFF_FFFF);
      repeat (15) idle();
      apb_read(8'h00, rd); check("t6_no_count", rd, 32'h0);
      apb_write(8'h04, 32'h1);
      cyc0 = cyc;
      read_at(21, 8'h00, rd); check("t6_resume", rd, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
